mem_bus_arbiter: RTL

//  Shares one single-port instruction/data memory between the CPU fetch port (i_*) and the load/store port (d_*).

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the load/store port.
// Fixed priority with a starvation guard; one fixed-latency access in flight at a time.
module mem_bus_arbiter #(
   parameter int unsigned AW            = 32,
   parameter int unsigned DW            = 32,
   parameter int unsigned MEM_LAT       = 1,
   parameter int unsigned DATA_PRIORITY = 1,
   parameter int unsigned MAX_STREAK    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            m_en,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   input  logic [DW-1:0]   m_rdata,
   output logic            busy
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned KW = $clog2(MAX_STREAK + 1);
   localparam logic PRIO_D = (DATA_PRIORITY != 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [KW-1:0]   streak_q, streak_d;
   logic            owner_q;          // 1 = data port owns the access
   logic            m_we_q;
   logic [AW-1:0]   m_addr_q;
   logic [DW-1:0]   m_wdata_q;
   logic [SW-1:0]   m_wstrb_q;

   logic            grant;
   logic            sel_d;
   logic            contended;

   always_comb begin
      contended = i_req & d_req;
      grant     = (state_q == IDLE) && (i_req || d_req) && !reset;
      if (contended) begin
         // Starvation guard: after MAX_STREAK contended wins the other port goes through.
         sel_d = (streak_q == KW'(MAX_STREAK)) ? !PRIO_D : PRIO_D;
      end else begin
         sel_d = d_req;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ISSUE;
               if (sel_d == PRIO_D) begin
                  if (contended && (streak_q != KW'(MAX_STREAK))) begin
                     streak_d = streak_q + KW'(1);
                  end
               end else begin
                  streak_d = '0;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CW'(MEM_LAT - 1);
            state_d = (MEM_LAT > 1) ? WAIT : RESP;
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
      end else if (grant) begin
         owner_q <= sel_d;
         if (sel_d) begin
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_wstrb_q <= d_wstrb;
         end else begin
            m_we_q    <= 1'b0;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
         end
      end
   end

   always_comb begin
      i_gnt    = grant & !sel_d;
      d_gnt    = grant & sel_d;
      busy     = (state_q != IDLE);
      m_en     = (state_q == ISSUE);
      m_we     = m_we_q;
      m_addr   = m_addr_q;
      m_wdata  = m_wdata_q;
      m_wstrb  = m_wstrb_q;
      i_rvalid = (state_q == RESP) && !owner_q;
      d_rvalid = (state_q == RESP) && owner_q;
      i_rdata  = i_rvalid ? m_rdata : '0;
      d_rdata  = (d_rvalid && !m_we_q) ? m_rdata : '0;
   end

endmodule
